// File: rtl/featuremap_stream_ctrl.sv
// Frame sequencer for an NUM_CH-channel conv2D/add_bias featuremap filter: gates the shared FIFO read,
// walks the padded raster, counts WIDTH*WIDTH results and reports done / sticky error (overflow, drain timeout).
module featuremap_stream_ctrl #(
    parameter int WIDTH   = 112,
    parameter int NUM_CH  = 8,
    parameter int TIMEOUT = 1024,
    parameter int CW      = $clog2(WIDTH + 2),
    parameter int OW      = $clog2(WIDTH * WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NUM_CH-1:0] fifo_empty,
    input  logic              out_afull,
    input  logic              valid_in,
    output logic              rdreq,
    output logic [CW-1:0]     col,
    output logic [CW-1:0]     row,
    output logic [OW-1:0]     out_count,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_POS    = CW'(WIDTH + 1);
    localparam logic [OW-1:0] FULL_CNT    = OW'(WIDTH * WIDTH);
    localparam logic [TW-1:0] TIMEOUT_CNT = TW'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  col_q, col_d;
    logic [CW-1:0]  row_q, row_d;
    logic [OW-1:0]  cnt_q, cnt_d;
    logic [TW-1:0]  idle_q, idle_d;
    logic           err_q, err_d;
    logic           last_read;
    logic           count_full;
    logic           timeout_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            idle_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            err_q   <= err_d;
        end
    end

    // Raster position, result count, drain idle counter and sticky error.
    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        cnt_d     = cnt_q;
        idle_d    = idle_q;
        err_d     = err_q;
        last_read = rdreq && (col_q == LAST_POS) && (row_q == LAST_POS);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    col_d  = '0;
                    row_d  = '0;
                    cnt_d  = '0;
                    idle_d = '0;
                    err_d  = 1'b0;
                end
            end
            S_FILL: begin
                idle_d = '0;
                if (rdreq) begin
                    if (col_q == LAST_POS) begin
                        col_d = '0;
                        row_d = (row_q == LAST_POS) ? '0 : row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                idle_d = valid_in ? '0 : idle_q + 1'b1;
            end
            default: ;
        endcase

        // A result outside an active frame, or beyond the expected total, is an error and not counted.
        if (valid_in) begin
            if ((state_q == S_FILL || state_q == S_DRAIN) && (cnt_q != FULL_CNT)) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        count_full  = (cnt_d == FULL_CNT);
        timeout_hit = (state_q == S_DRAIN) && (idle_d == TIMEOUT_CNT) && !count_full;
        if (timeout_hit) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_FILL;
            S_FILL:  if (last_read) state_d = count_full ? S_DONE : S_DRAIN;
            S_DRAIN: if (count_full || timeout_hit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rdreq     = (state_q == S_FILL) && ~|fifo_empty && ~out_afull;
        busy      = (state_q == S_FILL) || (state_q == S_DRAIN);
        done      = (state_q == S_DONE);
        col       = col_q;
        row       = row_q;
        out_count = cnt_q;
        err       = err_q;
    end

endmodule

// File: tb/tb_featuremap_stream_ctrl.sv
// Directed bench for featuremap_stream_ctrl at WIDTH=4 (6x6 padded frame, 16 results), TIMEOUT=16.
module tb_featuremap_stream_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] fifo_empty;
    logic       out_afull;
    logic       valid_in;
    logic       rdreq;
    logic [2:0] col;
    logic [2:0] row;
    logic [4:0] out_count;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;
    int exp_col;
    int exp_row;

    featuremap_stream_ctrl #(
        .WIDTH   (4),
        .NUM_CH  (8),
        .TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .fifo_empty (fifo_empty),
        .out_afull  (out_afull),
        .valid_in   (valid_in),
        .rdreq      (rdreq),
        .col        (col),
        .row        (row),
        .out_count  (out_count),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one cycle of inputs just after the edge, then settle so outputs can be sampled.
    task automatic cyc(input logic [7:0] fe, input logic af, input logic vin, input logic st);
        @(posedge clk);
        #1;
        fifo_empty = fe;
        out_afull  = af;
        valid_in   = vin;
        start      = st;
        #1;
    endtask

    task automatic advance_pos();
        if (exp_col == 5) begin
            exp_col = 0;
            exp_row = (exp_row == 5) ? 0 : exp_row + 1;
        end else begin
            exp_col = exp_col + 1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; fifo_empty = 8'h00; out_afull = 1'b0; valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (rdreq !== 1'b0 || col !== 3'd0 || row !== 3'd0 || out_count !== 5'd0 ||
            busy !== 1'b0 || done !== 1'b0 || err !== 1'b0)
            begin errors++; $display("FAIL reset: rdreq=%b col=%0d row=%0d cnt=%0d busy=%b done=%b err=%b, want all 0",
                              rdreq, col, row, out_count, busy, done, err); end
    endtask

    task automatic test_sweep_and_drain();
        int nreads = 0;
        exp_col = 0; exp_row = 0;
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 40; c++) begin
            cyc(8'h00, 1'b0, 1'b0, 1'b0);
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL sweep_busy: cycle %0d busy=%b want 1", c, busy); end
            if (rdreq === 1'b1) begin
                checks++;
                if (col !== exp_col[2:0] || row !== exp_row[2:0])
                    begin errors++; $display("FAIL sweep_pos: read %0d col=%0d row=%0d want %0d/%0d",
                                      nreads, col, row, exp_col, exp_row); end
                advance_pos();
                nreads++;
            end
        end
        checks++;
        if (nreads != 36) begin errors++; $display("FAIL sweep_reads: got %0d want 36", nreads); end
        repeat (16) cyc(8'h00, 1'b0, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_count !== 5'd16 || err !== 1'b0)
            begin errors++; $display("FAIL drain_done: done=%b busy=%b cnt=%0d err=%b want 1/0/16/0",
                              done, busy, out_count, err); end
        cyc(8'h00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || out_count !== 5'd16)
            begin errors++; $display("FAIL drain_idle: done=%b busy=%b cnt=%0d want 0/0/16", done, busy, out_count); end
    endtask

    // Empty-FIFO stall mid-frame, results on the last 16 reads: frame completes with no DRAIN cycle.
    task automatic test_empty_stall();
        int nreads = 0;
        int stall_left = 5;
        exp_col = 0; exp_row = 0;
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 60 && nreads < 36; c++) begin
            if (nreads == 10 && stall_left > 0) begin
                cyc(8'h10, 1'b0, 1'b0, 1'b0);
                stall_left--;
                checks++;
                if (rdreq !== 1'b0 || col !== exp_col[2:0] || row !== exp_row[2:0])
                    begin errors++; $display("FAIL empty_stall: rdreq=%b col=%0d row=%0d want 0 %0d/%0d",
                                      rdreq, col, row, exp_col, exp_row); end
            end else begin
                cyc(8'h00, 1'b0, (nreads >= 20), 1'b0);
                if (nreads == 0) begin
                    checks++;
                    if (out_count !== 5'd0) begin errors++; $display("FAIL start_clears_count: cnt=%0d want 0", out_count); end
                end
                checks++;
                if (rdreq !== 1'b1 || col !== exp_col[2:0] || row !== exp_row[2:0])
                    begin errors++; $display("FAIL empty_read: read %0d rdreq=%b col=%0d row=%0d want 1 %0d/%0d",
                                      nreads, rdreq, col, row, exp_col, exp_row); end
                advance_pos();
                nreads++;
            end
        end
        checks++;
        if (nreads != 36 || stall_left != 0)
            begin errors++; $display("FAIL empty_reads: reads=%0d stalls_left=%0d want 36/0", nreads, stall_left); end
        cyc(8'h00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_count !== 5'd16 || err !== 1'b0)
            begin errors++; $display("FAIL direct_done: done=%b busy=%b cnt=%0d err=%b want 1/0/16/0",
                              done, busy, out_count, err); end
        cyc(8'h00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_width: done=%b want 0", done); end
    endtask

    // out_afull pause, then only 15 results so the drain times out.
    task automatic test_afull_timeout();
        int nreads = 0;
        int pause_left = 3;
        exp_col = 0; exp_row = 0;
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 60 && nreads < 36; c++) begin
            if (nreads == 3 && pause_left > 0) begin
                cyc(8'h00, 1'b1, 1'b0, 1'b0);
                pause_left--;
                checks++;
                if (rdreq !== 1'b0 || col !== exp_col[2:0] || out_count !== 5'd0)
                    begin errors++; $display("FAIL afull_pause: rdreq=%b col=%0d cnt=%0d want 0 %0d 0",
                                      rdreq, col, out_count, exp_col); end
            end else begin
                cyc(8'h00, 1'b0, (nreads >= 5 && nreads < 20), 1'b0);
                checks++;
                if (rdreq !== 1'b1 || col !== exp_col[2:0] || row !== exp_row[2:0])
                    begin errors++; $display("FAIL afull_read: read %0d rdreq=%b col=%0d row=%0d want 1 %0d/%0d",
                                      nreads, rdreq, col, row, exp_col, exp_row); end
                advance_pos();
                nreads++;
            end
        end
        for (int c = 0; c < 16; c++) begin
            cyc(8'h00, 1'b0, 1'b0, 1'b0);
            checks++;
            if (busy !== 1'b1 || done !== 1'b0)
                begin errors++; $display("FAIL timeout_wait: idle cycle %0d busy=%b done=%b want 1/0", c, busy, done); end
        end
        cyc(8'h00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (done !== 1'b1 || err !== 1'b1 || out_count !== 5'd15 || busy !== 1'b0)
            begin errors++; $display("FAIL timeout_done: done=%b err=%b cnt=%0d busy=%b want 1/1/15/0",
                              done, err, out_count, busy); end
        cyc(8'h00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (err !== 1'b1 || done !== 1'b0)
            begin errors++; $display("FAIL err_sticky: err=%b done=%b want 1/0", err, done); end
    endtask

    // 17 results, a start while busy, then reset at read 20.
    task automatic test_overflow_busy_start_rst();
        exp_col = 0; exp_row = 0;
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        for (int r = 0; r < 20; r++) begin
            cyc(8'h00, 1'b0, (r < 17), (r == 5));
            if (r == 0) begin
                checks++;
                if (err !== 1'b0) begin errors++; $display("FAIL start_clears_err: err=%b want 0", err); end
            end
            if (r == 17) begin
                checks++;
                if (out_count !== 5'd16 || err !== 1'b1)
                    begin errors++; $display("FAIL overflow: cnt=%0d err=%b want 16/1", out_count, err); end
            end
            checks++;
            if (rdreq !== 1'b1 || col !== exp_col[2:0] || row !== exp_row[2:0] || busy !== 1'b1)
                begin errors++; $display("FAIL busy_start: read %0d rdreq=%b col=%0d row=%0d busy=%b want 1 %0d/%0d 1",
                                  r, rdreq, col, row, busy, exp_col, exp_row); end
            advance_pos();
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (rdreq !== 1'b0 || col !== 3'd0 || row !== 3'd0 || out_count !== 5'd0 ||
            busy !== 1'b0 || done !== 1'b0 || err !== 1'b0)
            begin errors++; $display("FAIL mid_rst: rdreq=%b col=%0d row=%0d cnt=%0d busy=%b done=%b err=%b want all 0",
                              rdreq, col, row, out_count, busy, done, err); end
        cyc(8'h00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (rdreq !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL post_rst_idle: rdreq=%b busy=%b want 0/0", rdreq, busy); end
    endtask

    initial begin
        test_reset();
        test_sweep_and_drain();
        test_empty_stall();
        test_afull_timeout();
        test_overflow_busy_start_rst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
